// File: rtl/lcd_spi_rx.sv
//------------------------------------------------------------------------------
// Module      : lcd_spi_rx
// Description : Oversampled mode-0 SPI slave receiver with FWFT frame FIFO,
//               sticky overrun / framing-error flags and a registered IRQ.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_spi_rx #(
    parameter int FRAME_BITS = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Reset,
    input  logic                  i_spi_sck,
    input  logic                  i_spi_mosi,
    input  logic                  i_spi_ss_n,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    input  logic                  i_irq_en,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_ovr,
    output logic                  o_frm_err,
    output logic                  o_irq
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = $clog2(FRAME_BITS);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(FRAME_BITS - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_addr_w:0]   c_ptr_one  = (c_addr_w + 1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  sck_m_q, sck_m_d, sck_s_q, sck_s_d, sck_h_q, sck_h_d;
    logic                  mosi_m_q, mosi_m_d, mosi_s_q, mosi_s_d;
    logic                  ss_m_q, ss_m_d, ss_s_q, ss_s_d;
    logic                  busy_q, busy_d;
    logic [c_cnt_w-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [c_addr_w:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  ovr_q, ovr_d, frm_err_q, frm_err_d, irq_q, irq_d;
    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];

    logic w_sck_rise, w_push, w_frm_set, w_empty, w_full, w_pop, w_do_push, w_ovr_set;

    assign w_sck_rise = sck_s_q & ~sck_h_q;
    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = (wr_ptr_q[c_addr_w] != rd_ptr_q[c_addr_w]) &&
                        (wr_ptr_q[c_addr_w-1:0] == rd_ptr_q[c_addr_w-1:0]);
    assign w_pop      = ~w_empty & i_rx_ready;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign w_do_push  = w_push & (~w_full | w_pop);
    assign w_ovr_set  = w_push & w_full & ~w_pop;

    always_comb begin
        sck_m_d   = i_spi_sck;
        sck_s_d   = sck_m_q;
        sck_h_d   = sck_s_q;
        mosi_m_d  = i_spi_mosi;
        mosi_s_d  = mosi_m_q;
        ss_m_d    = i_spi_ss_n;
        ss_s_d    = ss_m_q;
        busy_d    = ~ss_s_d;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        w_push    = 1'b0;
        w_frm_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!ss_s_q) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Slave-select release takes precedence over a coincident SCK edge.
                if (ss_s_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    w_frm_set = (bit_cnt_q != '0);
                end else if (w_sck_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s_q};
                    if (bit_cnt_q == c_cnt_last) begin
                        bit_cnt_d = '0;
                        w_push    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_cnt_one;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d  = w_do_push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
        rd_ptr_d  = w_pop     ? rd_ptr_q + c_ptr_one : rd_ptr_q;
        ovr_d     = w_ovr_set | (ovr_q & ~i_clr);
        frm_err_d = w_frm_set | (frm_err_q & ~i_clr);
        irq_d     = ((wr_ptr_d != rd_ptr_d) & i_irq_en) | ovr_d | frm_err_d;
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q   <= ST_IDLE;
            sck_m_q   <= 1'b0;
            sck_s_q   <= 1'b0;
            sck_h_q   <= 1'b0;
            mosi_m_q  <= 1'b0;
            mosi_s_q  <= 1'b0;
            ss_m_q    <= 1'b1;
            ss_s_q    <= 1'b1;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovr_q     <= 1'b0;
            frm_err_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sck_m_q   <= sck_m_d;
            sck_s_q   <= sck_s_d;
            sck_h_q   <= sck_h_d;
            mosi_m_q  <= mosi_m_d;
            mosi_s_q  <= mosi_s_d;
            ss_m_q    <= ss_m_d;
            ss_s_q    <= ss_s_d;
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovr_q     <= ovr_d;
            frm_err_q <= frm_err_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (w_do_push) mem_q[wr_ptr_q[c_addr_w-1:0]] <= shreg_d;
    end

    // Data is forced to zero while empty so stale entries never show after reset.
    assign o_rx_data  = w_empty ? '0 : mem_q[rd_ptr_q[c_addr_w-1:0]];
    assign o_rx_valid = ~w_empty;
    assign o_busy     = busy_q;
    assign o_ovr      = ovr_q;
    assign o_frm_err  = frm_err_q;
    assign o_irq      = irq_q;

endmodule

`default_nettype wire
